// File: rtl/wait_state_mem_port.sv
// wait_state_mem_port
// Memory-side responder for the req/gnt/rvalid core port. Backs a word
// addressed RAM plus two memory-mapped registers (flag, result) and inserts a
// programmable grant latency and response latency so that core stall paths
// can be exercised. At most one transaction is outstanding.
//
// Handshake: the initiator raises port_req_i with addr/we/be/wdata and holds
// them until it sees port_gnt_o high at a clock edge; that edge accepts the
// request. Exactly RVALID_DELAY cycles after the grant cycle, port_rvalid_o
// pulses for one cycle with port_rdata_o / port_err_o valid.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   port_req_i / port_gnt_o   request / grant (grant is combinational on req)
//   port_rvalid_o, port_err_o response strobe and its error flag
//   port_addr_i, port_we_i, port_be_i, port_wdata_i   request fields
//   port_rdata_o              read data, 0 outside rvalid and for writes
//   mem_flag, mem_result      flag and result registers
module wait_state_mem_port #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RVALID_DELAY = 1,
  parameter logic [31:0] FLAG_ADDR    = 32'h0000_FFF8,
  parameter logic [31:0] RESULT_ADDR  = 32'h0000_FFFC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        port_req_i,
  output logic        port_gnt_o,
  output logic        port_rvalid_o,
  output logic        port_err_o,
  input  logic [31:0] port_addr_i,
  input  logic        port_we_i,
  input  logic [3:0]  port_be_i,
  input  logic [31:0] port_wdata_i,
  output logic [31:0] port_rdata_o,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result
);

  localparam int unsigned WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  GNT_D    = 4'(GNT_DELAY);
  localparam logic [3:0]  RSP_LAST = 4'(RVALID_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    RESP_WAIT = 2'd2,
    RESP      = 2'd3
  } state_e;

  state_e                state_q;
  logic [3:0]            gnt_cnt_q;
  logic [3:0]            rsp_cnt_q;
  logic                  rsp_err_q;
  logic [31:0]           rsp_data_q;
  logic [31:0]           flag_q;
  logic [31:0]           result_q;
  logic [31:0]           ram_q [WORDS];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  hit_flag;
  logic                  hit_result;
  logic                  out_of_range;
  logic                  acc_err;
  logic                  ram_we;
  logic                  gnt;
  logic [31:0]           read_word;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  assign word_idx     = port_addr_i[ADDR_WIDTH-1:2];
  // Registers decode on the full address so they never alias into RAM.
  assign hit_flag     = (port_addr_i == FLAG_ADDR);
  assign hit_result   = (port_addr_i == RESULT_ADDR);
  assign out_of_range = ((port_addr_i >> ADDR_WIDTH) != 32'd0);
  assign acc_err      = out_of_range && !hit_flag && !hit_result;

  // Grant is blocked only while a response is still being counted down;
  // in RESP the next request may be accepted alongside the rvalid pulse.
  assign gnt = port_req_i && !rst_i && (state_q != RESP_WAIT) && (gnt_cnt_q == GNT_D);

  assign ram_we    = gnt && port_we_i && !acc_err && !hit_flag && !hit_result;
  assign read_word = hit_flag ? flag_q : (hit_result ? result_q : ram_q[word_idx]);

  // RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[word_idx] <= merge_be(ram_q[word_idx], port_wdata_i, port_be_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      gnt_cnt_q  <= 4'd0;
      rsp_cnt_q  <= 4'd0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= 32'd0;
      flag_q     <= 32'd0;
      result_q   <= 32'd0;
    end else if (gnt) begin
      gnt_cnt_q  <= 4'd0;
      // rsp_cnt_q counts cycles elapsed since the grant cycle.
      rsp_cnt_q  <= 4'd1;
      state_q    <= (RVALID_DELAY == 1) ? RESP : RESP_WAIT;
      rsp_err_q  <= acc_err;
      rsp_data_q <= (port_we_i || acc_err) ? 32'd0 : read_word;
      if (port_we_i && hit_flag)   flag_q   <= merge_be(flag_q, port_wdata_i, port_be_i);
      if (port_we_i && hit_result) result_q <= merge_be(result_q, port_wdata_i, port_be_i);
    end else begin
      // Grant counter saturates at GNT_DELAY while req is held; an early
      // drop of req clears it and nothing is accepted.
      if (port_req_i) begin
        if (gnt_cnt_q != GNT_D) gnt_cnt_q <= gnt_cnt_q + 4'd1;
      end else begin
        gnt_cnt_q <= 4'd0;
      end
      case (state_q)
        IDLE, RESP, WAIT_GNT: state_q <= port_req_i ? WAIT_GNT : IDLE;
        RESP_WAIT: begin
          if (rsp_cnt_q == RSP_LAST) state_q <= RESP;
          else rsp_cnt_q <= rsp_cnt_q + 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_gnt_o    = gnt;
  assign port_rvalid_o = (state_q == RESP);
  assign port_err_o    = port_rvalid_o && rsp_err_q;
  assign port_rdata_o  = port_rvalid_o ? rsp_data_q : 32'd0;
  assign mem_flag      = flag_q;
  assign mem_result    = result_q;

endmodule

// File: tb/tb_wait_state_mem_port.sv
// Bench for wait_state_mem_port: instance 0 uses minimal delays (0/1),
// instance 1 uses GNT_DELAY=3, RVALID_DELAY=4. Expected responses come from a
// small reference model and are queued at grant time, then checked in order
// when rvalid appears.
module tb_wait_state_mem_port;

  localparam logic [31:0] FLAG   = 32'h0000_FFF8;
  localparam logic [31:0] RESULT = 32'h0000_FFFC;

  logic        clk;
  logic        rst;
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic        err    [2];
  logic [31:0] rdata  [2];
  logic [31:0] flag   [2];
  logic [31:0] result [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  int          cyc_q0 [$];
  int          cyc_q1 [$];

  logic [31:0] model_mem [int];
  logic [31:0] model_flag   [2];
  logic [31:0] model_result [2];

  wait_state_mem_port #(.GNT_DELAY(0), .RVALID_DELAY(1)) u_fast (
    .clk_i(clk), .rst_i(rst),
    .port_req_i(req[0]), .port_gnt_o(gnt[0]), .port_rvalid_o(rvalid[0]),
    .port_err_o(err[0]), .port_addr_i(addr[0]), .port_we_i(we[0]),
    .port_be_i(be[0]), .port_wdata_i(wdata[0]), .port_rdata_o(rdata[0]),
    .mem_flag(flag[0]), .mem_result(result[0])
  );

  wait_state_mem_port #(.GNT_DELAY(3), .RVALID_DELAY(4)) u_slow (
    .clk_i(clk), .rst_i(rst),
    .port_req_i(req[1]), .port_gnt_o(gnt[1]), .port_rvalid_o(rvalid[1]),
    .port_err_o(err[1]), .port_addr_i(addr[1]), .port_we_i(we[1]),
    .port_be_i(be[1]), .port_wdata_i(wdata[1]), .port_rdata_o(rdata[1]),
    .mem_flag(flag[1]), .mem_result(result[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Returns the expected {err, rdata} and applies any write to the model.
  function automatic logic [32:0] model_access(input int d, input bit w, input logic [31:0] a,
                                               input logic [3:0] b, input logic [31:0] wd);
    int k;
    logic [31:0] old;
    if (a == FLAG) begin
      if (w) begin model_flag[d] = merge(model_flag[d], wd, b); return 33'd0; end
      return {1'b0, model_flag[d]};
    end
    if (a == RESULT) begin
      if (w) begin model_result[d] = merge(model_result[d], wd, b); return 33'd0; end
      return {1'b0, model_result[d]};
    end
    if (a[31:16] != 16'd0) return {1'b1, 32'd0};
    k = d * 65536 + int'(a[15:2]);
    old = model_mem.exists(k) ? model_mem[k] : 32'd0;
    if (w) begin model_mem[k] = merge(old, wd, b); return 33'd0; end
    return {1'b0, old};
  endfunction

  // ---------------- response monitors ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    int c;
    if (!rst) begin
      if (rvalid[0]) begin
        if (exp_q0.size() == 0) check("unexp_rvalid0", 1, 0);
        else begin
          e = exp_q0.pop_front();
          c = cyc_q0.pop_front();
          check("rsp0", {err[0], rdata[0]}, e);
          check("rvalid_lat0", cyc - c, 1);
        end
      end else check("quiet0", {err[0], rdata[0]}, 0);
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    int c;
    if (!rst) begin
      if (rvalid[1]) begin
        if (exp_q1.size() == 0) check("unexp_rvalid1", 1, 0);
        else begin
          e = exp_q1.pop_front();
          c = cyc_q1.pop_front();
          check("rsp1", {err[1], rdata[1]}, e);
          check("rvalid_lat1", cyc - c, 4);
        end
      end else check("quiet1", {err[1], rdata[1]}, 0);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    int n;
    bit got;
    logic [32:0] e;
    n = 0;
    got = 0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    while (!got && n < 40) begin
      @(negedge clk);
      if (gnt[d]) got = 1; else n++;
    end
    check("gnt_seen", got, 1);
    if (got) begin
      check("gnt_lat", n, (d == 0) ? 0 : 3);
      e = model_access(d, w, a, b, wd);
      if (d == 0) begin exp_q0.push_back(e); cyc_q0.push_back(cyc); end
      else        begin exp_q1.push_back(e); cyc_q1.push_back(cyc); end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", ((d == 0) ? exp_q0.size() : exp_q1.size()), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; be[d] = 0; wdata[d] = 0;
      model_flag[d] = 0; model_result[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ctrl", {gnt[d], rvalid[d], err[d]}, 0);
      check("rst_rdata", rdata[d], 0);
      check("rst_flag", flag[d], 0);
      check("rst_result", result[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read, minimal delays.
    issue(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(0, 0, 32'h10, 4'hF, 32'h0);
    req[0] = 0;
    drain(0);

    // Back-to-back: fill then read three words with req held throughout.
    issue(0, 1, 32'h0, 4'hF, 32'h0000_0A0A);
    issue(0, 1, 32'h4, 4'hF, 32'h0000_0B0B);
    issue(0, 1, 32'h8, 4'hF, 32'h0000_0C0C);
    issue(0, 0, 32'h0, 4'hF, 32'h0);
    issue(0, 0, 32'h4, 4'hF, 32'h0);
    issue(0, 0, 32'h8, 4'hF, 32'h0);
    req[0] = 0;
    drain(0);

    // Byte enables, including the be=0 no-op write.
    issue(0, 1, 32'h20, 4'hF, 32'h11223344);
    issue(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(0, 0, 32'h20, 4'hF, 32'h0);
    issue(0, 1, 32'h20, 4'h0, 32'hFFFF_FFFF);
    issue(0, 0, 32'h20, 4'h0, 32'h0);
    req[0] = 0;
    drain(0);

    // Random word traffic.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      ra = {16'd0, 6'd0, 8'($urandom_range(64, 127)), 2'b00};
      issue(0, 1, ra, 4'($urandom_range(0, 15)), $urandom);
      issue(0, 0, ra, 4'hF, 32'h0);
    end
    req[0] = 0;
    drain(0);

    // Flag/result registers and error response.
    issue(0, 1, FLAG, 4'hF, 32'd1);
    check("mem_flag", flag[0], model_flag[0]);
    issue(0, 1, RESULT, 4'hF, 32'd42);
    check("mem_result", result[0], model_result[0]);
    issue(0, 0, 32'h0001_0000, 4'hF, 32'h0);
    issue(0, 1, 32'h0001_0020, 4'hF, 32'h5555_5555);
    issue(0, 0, 32'h20, 4'hF, 32'h0);
    issue(0, 0, FLAG, 4'hF, 32'h0);
    req[0] = 0;
    drain(0);

    // Slow instance: grant after 3 waiting cycles, rvalid 4 after grant,
    // and no grant while the response is still pending.
    issue(1, 1, 32'h100, 4'hF, 32'h1357_9BDF);
    req[1] = 0;
    drain(1);
    issue(1, 0, 32'h100, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_gnt_resp_wait", gnt[1], 0);
    end
    @(posedge clk); #1;
    req[1] = 0;
    drain(1);

    // Reset in the middle of a pending response.
    issue(1, 1, FLAG, 4'hF, 32'd1);
    req[1] = 0;
    drain(1);
    check("slow_flag", flag[1], 32'd1);
    issue(1, 1, 32'h40, 4'hF, 32'hCAFE_F00D);
    req[1] = 0;
    drain(1);
    issue(1, 0, 32'h40, 4'hF, 32'h0);
    req[1] = 0;
    rst = 1'b1;
    exp_q1.delete();
    cyc_q1.delete();
    for (int d = 0; d < 2; d++) begin model_flag[d] = 0; model_result[d] = 0; end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_ctrl", {gnt[1], rvalid[1], err[1]}, 0);
      check("post_rst_rdata", rdata[1], 0);
      check("post_rst_flag", flag[1], 0);
    end
    @(posedge clk); #1;
    issue(1, 0, 32'h40, 4'hF, 32'h0);
    req[1] = 0;
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wait_state_mem_port.md
Name: wait_state_mem_port

Overview:
- Memory-side responder for the core's req/gnt/rvalid instruction/data port protocol.
- Backs a word-addressed RAM and adds programmable grant and response latency, so core stall paths can be exercised.
- Exposes the memory-mapped flag and result registers that testbenches poll for end-of-test.
- Drop-in for the data or instruction side of the single-core SoC.

Parameters:
- ADDR_WIDTH, 16: byte-address span; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- GNT_DELAY, 0: cycles req_i must be held before gnt_o asserts (0..15).
- RVALID_DELAY, 1: cycles from the gnt cycle to the rvalid cycle (1..15).
- FLAG_ADDR, 32'h0000_FFF8: byte address of the flag register.
- RESULT_ADDR, 32'h0000_FFFC: byte address of the result register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- port_req_i  in  1  request; held by the initiator until granted
- port_gnt_o  out  1  grant; one-cycle pulse that accepts the request
- port_rvalid_o  out  1  response valid; one-cycle pulse
- port_err_o  out  1  error; qualified by port_rvalid_o
- port_addr_i  in  32  byte address
- port_we_i  in  1  1 = write, 0 = read
- port_be_i  in  4  byte enables
- port_wdata_i  in  32  write data
- port_rdata_o  out  32  read data; qualified by port_rvalid_o
- mem_flag  out  32  flag register
- mem_result  out  32  result register

Behaviour:
- Reset (rst_i high at a clk_i edge): gnt, rvalid and err are 0; rdata is 0; mem_flag and mem_result are 0; the FSM enters IDLE and the grant counter is 0. RAM contents are not reset. A pending response is discarded: no rvalid is issued after reset.
- FSM states:
  - IDLE: no request pending.
  - WAIT_GNT: counting grant delay.
  - RESP_WAIT: counting response delay.
  - RESP: rvalid cycle.
- Grant rules:
  - port_gnt_o = port_req_i AND (state in IDLE/WAIT_GNT/RESP) AND (grant counter == GNT_DELAY). It is combinational on req.
  - With GNT_DELAY = 0, gnt is issued in the same cycle req rises.
  - With GNT_DELAY = N, the counter increments each cycle req is held without gnt, and gnt asserts in the (N+1)th cycle of req.
  - The counter clears on gnt, or if req drops before gnt. Dropping req early is an initiator violation; it is tolerated and nothing is accepted.
- Accept: on the gnt cycle edge, addr, we, be and wdata are captured.
  - A write updates the selected bytes of the RAM word addr[ADDR_WIDTH-1:2], or of the flag/result register, at this edge.
  - A read samples the target at this edge. A read therefore returns data including any write accepted on an earlier edge.
- Response:
  - port_rvalid_o is high exactly RVALID_DELAY cycles after the gnt cycle, for one cycle. RESP_WAIT is skipped when RVALID_DELAY = 1.
  - For reads, rdata holds the captured word and is 0 outside rvalid.
  - For writes, rdata is 0 during rvalid.
- Outstanding limit: one.
  - gnt is never asserted in RESP_WAIT.
  - In RESP, a new request may be granted in the same cycle as rvalid, giving back-to-back throughput of one transaction per RVALID_DELAY+GNT_DELAY... cycles. With both delays minimal, throughput is one transaction per cycle.
- Error: a byte address with any bit at or above ADDR_WIDTH set, other than FLAG_ADDR or RESULT_ADDR, is granted normally.
  - No write occurs.
  - The rvalid cycle has err = 1 and rdata = 0.
  - err is 0 in every other cycle.
- Flag/result decode uses the full 32-bit address. The flag and result registers are not aliased into RAM.
- Byte enables: be = 0 on a write is a legal no-op and still responds. Reads ignore be and return the full word.

Test Plan:
- Reset, then GNT_DELAY=0 and RVALID_DELAY=1. Write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> gnt in the req cycle, rvalid the next cycle, rdata 32'hDEADBEEF, err 0.
- GNT_DELAY=3, RVALID_DELAY=4, read with req held -> gnt in the 4th req cycle, rvalid exactly 4 cycles after gnt, no gnt during RESP_WAIT.
- Back-to-back reads of 0x0, 0x4 and 0x8 with both delays minimal and req held continuously -> gnt high for 3 consecutive cycles, rvalid for 3 consecutive cycles, in order.
- Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with be=4'b0101, then read 0x20 -> rdata 32'h11BB33DD.
- Write 1 to FLAG_ADDR and 32'd42 to RESULT_ADDR -> mem_flag = 1 and mem_result = 42 after the gnt edges. A read of 0x0001_0000 -> rvalid with err = 1 and rdata 0.
- Assert rst_i during RESP_WAIT (RVALID_DELAY=4) -> no rvalid follows, all outputs are 0, mem_flag is 0, and RAM data written before the reset is still readable.
